writeback_arbiter: RTL and testbench

Writeback stage of core_lapido, directly upstream of `register_file`. It merges two result producers onto the register file's single write port: the single-cycle ALU path and the variable-latency memory/multiply path. Memory results are buffered in a small FIFO, and the block drives `en`/`rd`/`data` of `register_file` from registered outputs. A starvation counter guarantees that buffered memory results drain even under continuous ALU traffic.

---
 rtl/writeback_arbiter_pkg.sv | 39 +++
 rtl/writeback_arbiter_if.sv | 48 ++++
 rtl/writeback_arbiter_wb_fifo.sv | 77 +++++++
 rtl/writeback_arbiter.sv | 144 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_pkg
// Description : Shared widths, the write-entry record and the grant-source
//               encoding used by the writeback arbiter and its result FIFO.
//               DATA_W / REG_ADDR_W match register_file and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_arbiter_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One pending register-file write.
  typedef struct packed {
    reg_addr_t rd;
    data_t     data;
  } wb_entry_t;

  // Which producer owns the write port in a given cycle.
  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_ALU    = 2'd1,
    GRANT_FIFO   = 2'd2,
    GRANT_BYPASS = 2'd3
  } grant_src_t;

  function automatic wb_entry_t make_entry(input reg_addr_t rd, input data_t data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_if
// Description : Result-producer and register-file write-port bundle of the
//               writeback stage.
//               master : producer / environment side (drives results)
//               slave  : writeback_arbiter side (drives stall/ready/wb_*)
//   alu_valid/alu_rd/alu_data   ALU result, held by upstream while alu_stall
//   alu_stall                   ALU result not consumed this cycle
//   mem_valid/mem_rd/mem_data   memory/mul result
//   mem_ready                   memory result accepted when valid && ready
//   mem_pending                 buffered memory results exist
//   wb_en/wb_rd/wb_data         register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if;

  logic                              alu_valid;
  writeback_arbiter_pkg::reg_addr_t  alu_rd;
  writeback_arbiter_pkg::data_t      alu_data;
  logic                              alu_stall;

  logic                              mem_valid;
  writeback_arbiter_pkg::reg_addr_t  mem_rd;
  writeback_arbiter_pkg::data_t      mem_data;
  logic                              mem_ready;
  logic                              mem_pending;

  logic                              wb_en;
  writeback_arbiter_pkg::reg_addr_t  wb_rd;
  writeback_arbiter_pkg::data_t      wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_stall, mem_ready, mem_pending,
    input  wb_en, wb_rd, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_stall, mem_ready, mem_pending,
    output wb_en, wb_rd, wb_data
  );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer of pending memory-result writes. Synchronous
//               push/pop, asynchronous active-low reset, head visible
//               combinationally.
//   clk, rst           clock, async active-low reset
//   i_push/i_push_entry enqueue an entry
//   i_pop              dequeue the head
//   count              current occupancy (0..DEPTH)
//   head_rd/head_data  oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output reg_addr_t                  head_rd,
  output data_t                      head_data
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_pop;
  logic               w_do_push;

  // A push into a full buffer is allowed only when the head leaves in the
  // same cycle; the write then lands in the slot being vacated.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

  // Storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count     = r_count;
  assign head_rd   = r_mem[r_rd_ptr].rd;
  assign head_data = r_mem[r_rd_ptr].data;

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Merges the single-cycle ALU path and the buffered
//               memory/multiply path onto the single register-file write
//               port. Priority: ALU, FIFO head, memory bypass. A starvation
//               counter stalls the ALU for one cycle so buffered results
//               always drain.
//   clk   core clock, rising edge
//   rst   asynchronous active-low reset
//   bus   writeback_arbiter_if.slave (results in, stall/ready/write port out)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_arbiter_if.slave   bus
);

  localparam int c_CNT_W    = $clog2(DEPTH + 1);
  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0]    c_DEPTH  = c_CNT_W'(DEPTH);
  localparam logic [c_STARVE_W-1:0] c_SLIMIT = c_STARVE_W'(STARVE_LIMIT);

  // Registered state and outputs
  logic                  r_alu_stall;
  logic                  r_mem_ready;
  logic                  r_mem_pending;
  logic                  r_wb_en;
  reg_addr_t             r_wb_rd;
  data_t                 r_wb_data;
  logic [c_STARVE_W-1:0] r_starve;

  // Combinational
  logic                  w_alu_take;
  logic                  w_mem_take;
  logic                  w_fifo_empty;
  grant_src_t            w_grant;
  logic                  w_push;
  logic                  w_pop;
  logic [c_CNT_W-1:0]    w_count;
  logic [c_CNT_W-1:0]    w_count_next;
  logic [c_STARVE_W-1:0] w_starve_next;
  reg_addr_t             w_head_rd;
  data_t                 w_head_data;
  reg_addr_t             w_wr_rd;
  data_t                 w_wr_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (make_entry(bus.mem_rd, bus.mem_data)),
    .i_pop        (w_pop),
    .count        (w_count),
    .head_rd      (w_head_rd),
    .head_data    (w_head_data)
  );

  // Handshakes are qualified by the registered stall/ready, so neither
  // output has a combinational path from the inputs.
  assign w_alu_take   = bus.alu_valid && !r_alu_stall;
  assign w_mem_take   = bus.mem_valid && r_mem_ready;
  assign w_fifo_empty = (w_count == '0);

  always_comb begin
    w_grant   = GRANT_NONE;
    w_wr_rd   = r_wb_rd;
    w_wr_data = r_wb_data;
    if (w_alu_take) begin
      w_grant   = GRANT_ALU;
      w_wr_rd   = bus.alu_rd;
      w_wr_data = bus.alu_data;
    end else if (!w_fifo_empty) begin
      w_grant   = GRANT_FIFO;
      w_wr_rd   = w_head_rd;
      w_wr_data = w_head_data;
    end else if (w_mem_take) begin
      // Bypass only when nothing older is buffered, preserving order.
      w_grant   = GRANT_BYPASS;
      w_wr_rd   = bus.mem_rd;
      w_wr_data = bus.mem_data;
    end
  end

  assign w_pop  = (w_grant == GRANT_FIFO);
  assign w_push = w_mem_take && (w_grant != GRANT_BYPASS);

  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop) begin
      w_count_next = w_count + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - c_CNT_W'(1);
    end
  end

  // Counts ALU wins over a non-empty FIFO. Reaching the limit stalls the ALU
  // for one cycle, which forces a pop and thereby clears the counter.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_fifo_empty) begin
      w_starve_next = '0;
    end else if ((w_grant == GRANT_ALU) && (r_starve != c_SLIMIT)) begin
      w_starve_next = r_starve + c_STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_stall   <= 1'b0;
      r_mem_ready   <= 1'b0;
      r_mem_pending <= 1'b0;
      r_wb_en       <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
      r_starve      <= '0;
    end else begin
      r_wb_en       <= (w_grant != GRANT_NONE);
      r_wb_rd       <= w_wr_rd;
      r_wb_data     <= w_wr_data;
      r_starve      <= w_starve_next;
      r_alu_stall   <= (w_starve_next == c_SLIMIT);
      r_mem_ready   <= (w_count_next < c_DEPTH);
      r_mem_pending <= (w_count_next != '0);
    end
  end

  assign bus.alu_stall   = r_alu_stall;
  assign bus.mem_ready   = r_mem_ready;
  assign bus.mem_pending = r_mem_pending;
  assign bus.wb_en       = r_wb_en;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter: directed reset,
//               ALU, bypass, mid-operation reset and full-FIFO sequences, a
//               table of collision/starvation vectors, and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  writeback_arbiter_if bus ();

  writeback_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve;
  logic        m_stall, m_ready, m_pend, m_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_ready  = 1'b0;
    m_pend   = 1'b0;
    m_en     = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endtask

  // One clock edge of the writeback stage as described by its rules.
  task automatic model_step();
    bit   alu_take, mem_take, was_empty, popped, bypassed;
    ent_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    alu_take  = bus.alu_valid && !m_stall;
    mem_take  = bus.mem_valid && m_ready;
    was_empty = (m_q.size() == 0);
    popped    = 0;
    bypassed  = 0;
    m_en      = 1'b0;
    if (alu_take) begin
      m_en = 1'b1; m_rd = bus.alu_rd; m_data = bus.alu_data;
    end else if (!was_empty) begin
      e = m_q.pop_front();
      m_en = 1'b1; m_rd = e.rd; m_data = e.data;
      popped = 1;
    end else if (mem_take) begin
      m_en = 1'b1; m_rd = bus.mem_rd; m_data = bus.mem_data;
      bypassed = 1;
    end
    if (mem_take && !bypassed) m_q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
    if (popped || was_empty) m_starve = 0;
    else if (alu_take)       m_starve = m_starve + 1;
    m_stall = (m_starve == STARVE_LIMIT);
    m_ready = (m_q.size() < DEPTH);
    m_pend  = (m_q.size() != 0);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic [4:0] rd,
                           input logic [31:0] data, input logic st,
                           input logic rdy, input logic pend);
    check({tag, ".wb_en"},       32'(bus.wb_en),       32'(en));
    check({tag, ".wb_rd"},       32'(bus.wb_rd),       32'(rd));
    check({tag, ".wb_data"},     bus.wb_data,          data);
    check({tag, ".alu_stall"},   32'(bus.alu_stall),   32'(st));
    check({tag, ".mem_ready"},   32'(bus.mem_ready),   32'(rdy));
    check({tag, ".mem_pending"}, 32'(bus.mem_pending), 32'(pend));
  endtask

  // Advance one edge; DUT and model see the same stable inputs.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
    logic        e_pend;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Collision and fill: ALU continuous, two memory results, two forced stalls.
    // Upstream holds the stalled ALU result (rd 6 at rows 5-6, rd 10 at 10-11).
    tbl[0]  = '{1'b1, 5'd1,  32'h101, 1'b1, 5'd9,  32'h11, 1'b1, 5'd1,  32'h101, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 5'd2,  32'h102, 1'b1, 5'd10, 32'h22, 1'b1, 5'd2,  32'h102, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 5'd3,  32'h103, 1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'h103, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 5'd4,  32'h104, 1'b0, 5'd0,  32'h0,  1'b1, 5'd4,  32'h104, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 5'd5,  32'h105, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'h105, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 5'd6,  32'h106, 1'b0, 5'd0,  32'h0,  1'b1, 5'd9,  32'h11,  1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 5'd6,  32'h106, 1'b0, 5'd0,  32'h0,  1'b1, 5'd6,  32'h106, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 5'd7,  32'h107, 1'b0, 5'd0,  32'h0,  1'b1, 5'd7,  32'h107, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 5'd8,  32'h108, 1'b0, 5'd0,  32'h0,  1'b1, 5'd8,  32'h108, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 5'd9,  32'h109, 1'b0, 5'd0,  32'h0,  1'b1, 5'd9,  32'h109, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 5'd10, 32'h10A, 1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'h22,  1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd10, 32'h10A, 1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'h10A, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd10, 32'h10A, 1'b0, 1'b1, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    model_reset();

    // Reset and idle
    #2 rst = 1'b0;
    #1 check_all("rst_async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("rst_hold", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    step();
    check_all("rst_release", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    check_all("idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

    // ALU-only path
    drive(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'h0);
    step();
    check_all("alu_wr", 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_all("alu_idle", 1'b0, 5'd3, 32'hAA, 1'b0, 1'b1, 1'b0);

    // Memory bypass
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    check_all("bypass", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_all("bypass_idle", 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);

    // Collision, fill and starvation table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      step();
      check_all($sformatf("tbl[%0d]", i), tbl[i].e_en, tbl[i].e_rd, tbl[i].e_data,
                tbl[i].e_stall, tbl[i].e_ready, tbl[i].e_pend);
    end

    // Reset mid-operation with two buffered entries
    drive(1'b1, 5'd4, 32'h304, 1'b1, 5'd20, 32'h20);
    step();
    check_all("mrst_fill0", 1'b1, 5'd4, 32'h304, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 5'd5, 32'h305, 1'b1, 5'd21, 32'h21);
    step();
    check_all("mrst_fill1", 1'b1, 5'd5, 32'h305, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("mrst_async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("mrst_hold", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("mrst_after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    end

    // Full FIFO: rejected memory result while the head pops
    drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd12, 32'h12);
    step();
    check_all("full_s1", 1'b1, 5'd1, 32'h201, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 5'd2, 32'h202, 1'b1, 5'd13, 32'h13);
    step();
    check_all("full_s2", 1'b1, 5'd2, 32'h202, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h14);
    step();
    check_all("full_s3", 1'b1, 5'd12, 32'h12, 1'b0, 1'b1, 1'b1);
    step();
    check_all("full_s4", 1'b1, 5'd13, 32'h13, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_all("full_s5", 1'b1, 5'd14, 32'h14, 1'b0, 1'b1, 1'b0);
    step();
    check_all("full_s6", 1'b0, 5'd14, 32'h14, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if (!(bus.alu_valid && m_stall)) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_rd    = 5'($urandom);
        bus.alu_data  = $urandom;
      end
      bus.mem_valid = ($urandom_range(0, 1) == 1);
      bus.mem_rd    = 5'($urandom);
      bus.mem_data  = $urandom;
      step();
      check_all("rand", m_en, m_rd, m_data, m_stall, m_ready, m_pend);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
